uop_debounce2: RTL

UOP_DEBOUNCE2 -- requirements
Module: uop_debounce2

---
 rtl/uop_debounce_pkg.sv | 13 +
 rtl/uop_debounce2_if.sv | 17 +
 rtl/uop_debounce_ch.sv | 121 ++++++++++++
 rtl/uop_debounce2.sv | 37 +++
 4 files changed

// File: rtl/uop_debounce_pkg.sv
// Shared types for the two-channel switch debouncer.
// Latency: none (types only).
// Backpressure: none.
package uop_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_e;

endpackage

// File: rtl/uop_debounce2_if.sv
// Signal bundle for the two-channel debouncer: raw switch inputs and debounced outputs.
// Latency: none (wires only).
// Backpressure: none; levels and pulses are free-running.
interface uop_debounce2_if;

    logic       raw_a;
    logic       raw_b;
    logic       x;
    logic       y;
    logic [1:0] rise;
    logic [1:0] fall;

    // master drives the switches, slave is the debouncer
    modport master (output raw_a, output raw_b, input x, input y, input rise, input fall);
    modport slave  (input raw_a, input raw_b, output x, output y, output rise, output fall);

endinterface

// File: rtl/uop_debounce_ch.sv
// Single debounce channel: 2-flop synchroniser, 4-state FSM, hold counter, edge pulses.
// Latency: output follows a held level STABLE_COUNT+1 edges after raw is first sampled.
// Backpressure: none; all outputs are registered every cycle.
module uop_debounce_ch
    import uop_debounce_pkg::*;
#(
    parameter int STABLE_COUNT = 4
) (
    input  logic i_clk,
    input  logic i_n_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW     = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_COUNT - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic          r_s1;
    logic          r_s2;
    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          w_level_nxt;
    logic          w_rise_nxt;
    logic          w_fall_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_n_reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= STABLE_LO;
            r_count <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // count holds the number of consecutive s2 samples seen at the new level
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = '0;
        case (r_state)
            STABLE_LO: begin
                if (r_s2) begin
                    if (STABLE_COUNT == 1) begin
                        w_state_nxt = STABLE_HI;
                    end else begin
                        w_state_nxt = WAIT_HI;
                        w_count_nxt = C_ONE;
                    end
                end
            end
            WAIT_HI: begin
                if (!r_s2) begin
                    w_state_nxt = STABLE_LO;
                end else if (r_count == C_LAST) begin
                    w_state_nxt = STABLE_HI;
                end else begin
                    w_count_nxt = r_count + C_ONE;
                end
            end
            STABLE_HI: begin
                if (!r_s2) begin
                    if (STABLE_COUNT == 1) begin
                        w_state_nxt = STABLE_LO;
                    end else begin
                        w_state_nxt = WAIT_LO;
                        w_count_nxt = C_ONE;
                    end
                end
            end
            WAIT_LO: begin
                if (r_s2) begin
                    w_state_nxt = STABLE_HI;
                end else if (r_count == C_LAST) begin
                    w_state_nxt = STABLE_LO;
                end else begin
                    w_count_nxt = r_count + C_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
            end
        endcase
    end

    // a WAIT_* state falling back to its own stable state is a rejected glitch: no pulse
    always_comb begin
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (w_state_nxt == STABLE_HI && (r_state == WAIT_HI || r_state == STABLE_LO)) begin
            w_level_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
        end else if (w_state_nxt == STABLE_LO && (r_state == WAIT_LO || r_state == STABLE_HI)) begin
            w_level_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/uop_debounce2.sv
// Two independent debounced switch channels (A -> x, B -> y) with edge pulses.
// Latency: STABLE_COUNT+1 edges from first raw sample at a held level to output.
// Backpressure: none; outputs are registered levels and one-cycle pulses.
module uop_debounce2
    import uop_debounce_pkg::*;
#(
    parameter int STABLE_COUNT = 4
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       raw_a,
    input  logic       raw_b,
    output logic       x,
    output logic       y,
    output logic [1:0] rise,
    output logic [1:0] fall
);

    uop_debounce_ch #(.STABLE_COUNT(STABLE_COUNT)) u_ch_a (
        .i_clk     (clk),
        .i_n_reset (n_reset),
        .i_raw     (raw_a),
        .o_level   (x),
        .o_rise    (rise[0]),
        .o_fall    (fall[0])
    );

    uop_debounce_ch #(.STABLE_COUNT(STABLE_COUNT)) u_ch_b (
        .i_clk     (clk),
        .i_n_reset (n_reset),
        .i_raw     (raw_b),
        .o_level   (y),
        .o_rise    (rise[1]),
        .o_fall    (fall[1])
    );

endmodule
